sm_accum_ctrl: RTL and testbench

- Sequencer that drives one shared combinational sign-magnitude adder (sign = MSB, magnitude = low WIDTH-1 bits) to accumulate a stream of terms.
- Computes bias + sum of num_terms inputs for one neuron.
- Sits between the weighted-product stream and the activation stage.
- Adds saturation, -0 normalization, and valid/ready handshakes around the adder.

---
 rtl/sm_accum_ctrl.sv | 121 ++++++++++++
 tb/tb_sm_accum_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sm_accum_ctrl.sv
// Purpose : sequences a shared sign-magnitude adder to compute bias + sum of num_terms terms.
// Latency : one term per cycle; out_valid rises the cycle after the last accepted term.
// Backpr. : in_ready only in ACC; result held stable in DONE until out_ready.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start/num_terms/bias  job request, sampled only in IDLE
//   in_valid/in_data      term stream; in_ready accepts
//   add_a/add_b/add_sum   external combinational adder (a = acc, b = in_data)
//   out_valid/out_data    result; out_ready accepts
//   busy, ovf             not-idle flag, sticky saturation flag of current/last job
module sm_accum_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic [WIDTH-1:0] bias,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic             ovf
);

  localparam int MW = WIDTH - 1;  // magnitude width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ovf_q, ovf_nxt;

  // Any zero-magnitude value is stored as +0 so -0 never reaches the output.
  function automatic logic [WIDTH-1:0] norm_zero(input logic [WIDTH-1:0] v);
    return (v[MW-1:0] == '0) ? '0 : v;
  endfunction

  logic [MW-1:0]    acc_mag, in_mag, sum_mag, max_mag;
  logic             same_sign, wrap;
  logic [WIDTH-1:0] upd_val;

  assign add_a = acc;
  assign add_b = in_data;

  assign acc_mag   = acc[MW-1:0];
  assign in_mag    = in_data[MW-1:0];
  assign sum_mag   = add_sum[MW-1:0];
  assign max_mag   = (acc_mag > in_mag) ? acc_mag : in_mag;
  assign same_sign = (acc[MW] == in_data[MW]);
  // Like-signed addition whose magnitude shrank below an operand has wrapped.
  assign wrap      = same_sign && (sum_mag < max_mag);
  assign upd_val   = wrap ? {in_data[MW], {MW{1'b1}}} : norm_zero(add_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          acc_nxt   = norm_zero(bias);
          cnt_nxt   = num_terms;
          ovf_nxt   = 1'b0;
          state_nxt = (num_terms == '0) ? ST_DONE : ST_ACC;
        end
      end
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_nxt = upd_val;
          cnt_nxt = cnt - CNT_W'(1);
          if (wrap) ovf_nxt = 1'b1;
          if (cnt == CNT_W'(1)) state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        out_data  = acc;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_sm_accum_ctrl.sv
// Purpose : exercises sm_accum_ctrl against an integer reference of bias + clamped running sum.
// Latency : n/a (testbench).
// Backpr. : drives out_ready low for programmable stretches.
module tb_sm_accum_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  num_terms;
  logic [15:0] bias;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] add_a, add_b, add_sum;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        ovf;

  int checks = 0;
  int errors = 0;
  logic [15:0] term_q[$];

  always #5 clk = ~clk;

  sm_accum_ctrl #(.WIDTH(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_terms(num_terms), .bias(bias),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .ovf(ovf)
  );

  // Plain sign-magnitude adder; like-signed magnitudes wrap modulo 2^15.
  always_comb begin
    logic [15:0] ma, mb, t;
    ma = {1'b0, add_a[14:0]};
    mb = {1'b0, add_b[14:0]};
    t  = '0;
    add_sum = '0;
    if (add_a[15] == add_b[15]) begin
      t = ma + mb;
      add_sum = {add_a[15], t[14:0]};
    end else if (ma >= mb) begin
      t = ma - mb;
      add_sum = {add_a[15], t[14:0]};
    end else begin
      t = mb - ma;
      add_sum = {add_b[15], t[14:0]};
    end
  end

  function automatic int dec(input logic [15:0] w);
    int m;
    m = int'(w[14:0]);
    return w[15] ? -m : m;
  endfunction

  function automatic logic [15:0] enc(input int v);
    int m;
    m = (v < 0) ? -v : v;
    return {(v < 0), m[14:0]};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one job with the terms in term_q; the model is an integer sum clamped to +/-32767.
  task automatic run_job(input logic [15:0] b, input int max_gap, input int bp, input bit pulse);
    int m_acc, n, gap, s;
    bit m_ovf;
    n = term_q.size();
    m_acc = dec(b);
    m_ovf = 1'b0;
    @(posedge clk); #1;
    check_val("idle_busy", 32'(busy), 32'd0);
    check_val("idle_in_ready", 32'(in_ready), 32'd0);
    start = 1'b1; num_terms = 8'(n); bias = b;
    @(posedge clk); #1;
    start = 1'b0; num_terms = 8'($urandom); bias = 16'($urandom);
    check_val("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      if (pulse && i == 0 && gap == 0) gap = 1;
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        in_data  = 16'($urandom);
        if (pulse && g == 0) start = 1'b1;
        check_val("gap_in_ready", 32'(in_ready), 32'd1);
        check_val("gap_acc_hold", 32'(add_a), 32'(enc(m_acc)));
        check_val("gap_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = term_q[i];
      check_val("acc_in_ready", 32'(in_ready), 32'd1);
      check_val("acc_value", 32'(add_a), 32'(enc(m_acc)));
      check_val("acc_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      s = m_acc + dec(term_q[i]);
      if (s > 32767) begin s = 32767; m_ovf = 1'b1; end
      if (s < -32767) begin s = -32767; m_ovf = 1'b1; end
      m_acc = s;
    end
    for (int k = 0; k <= bp; k++) begin
      out_ready = (k == bp);
      check_val("done_out_valid", 32'(out_valid), 32'd1);
      check_val("done_out_data", 32'(out_data), 32'(enc(m_acc)));
      check_val("done_ovf", 32'(ovf), 32'(m_ovf));
      check_val("done_busy", 32'(busy), 32'd1);
      check_val("done_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check_val("post_out_valid", 32'(out_valid), 32'd0);
    check_val("post_busy", 32'(busy), 32'd0);
    check_val("post_ovf_held", 32'(ovf), 32'(m_ovf));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; num_terms = '0; bias = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    term_q = '{16'h0005, 16'h8003, 16'h0010};
    run_job(16'h0000, 0, 0, 1'b0);
    term_q = '{};
    run_job(16'h8007, 0, 2, 1'b0);
    term_q = '{16'h0020, 16'h8001};
    run_job(16'h7FF0, 0, 0, 1'b0);
    check_val("sat_ovf_idle", 32'(ovf), 32'd1);
    term_q = '{16'h8020};
    run_job(16'hFFF0, 0, 1, 1'b0);
    term_q = '{16'h8004};
    run_job(16'h0004, 0, 5, 1'b0);
    term_q = '{};
    repeat (4) term_q.push_back(16'($urandom));
    run_job(16'($urandom), 3, 0, 1'b1);

    // Asynchronous reset after two of four terms.
    @(posedge clk); #1;
    start = 1'b1; num_terms = 8'd4; bias = 16'h0010;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = 16'h0001;
    @(posedge clk); #1;
    in_data = 16'h0002;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_val("mid_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", 32'(busy), 32'd0);
    check_val("arst_in_ready", 32'(in_ready), 32'd0);
    check_val("arst_out_valid", 32'(out_valid), 32'd0);
    check_val("arst_out_data", 32'(out_data), 32'd0);
    check_val("arst_ovf", 32'(ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check_val("post_rst_out_valid", 32'(out_valid), 32'd0);
      check_val("post_rst_busy", 32'(busy), 32'd0);
    end
    term_q = '{16'h0003, 16'h0004};
    run_job(16'h8001, 1, 0, 1'b0);

    for (int j = 0; j < 30; j++) begin
      int n;
      n = $urandom_range(0, 6);
      term_q = '{};
      for (int t = 0; t < n; t++) term_q.push_back(16'($urandom));
      run_job(16'($urandom), 3, $urandom_range(0, 3), (j % 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
